// File: rtl/data_memory_pkg.sv
// Shared definitions for the data-memory controller: MMIO addresses, FSM states
// and the address decoder used to classify each access.
package data_memory_pkg;

    localparam logic [31:0] RX_DATA = 32'hFFFF_FFF0;
    localparam logic [31:0] RX_STAT = 32'hFFFF_FFF1;
    localparam logic [31:0] TX_DATA = 32'hFFFF_FFF2;

    typedef enum logic [1:0] {
        IDLE,
        RD1,
        RX_WAIT,
        TX_WAIT
    } dmem_state_t;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_RX_DATA,
        REG_RX_STAT,
        REG_TX_DATA,
        REG_NONE
    } dmem_region_t;

    function automatic dmem_region_t decode(input logic [31:0] addr, input int unsigned ram_words);
        if (addr < ram_words) return REG_RAM;
        case (addr)
            RX_DATA: return REG_RX_DATA;
            RX_STAT: return REG_RX_STAT;
            TX_DATA: return REG_TX_DATA;
            default: return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_controller_if.sv
// Core-side data-memory port: the core drives the access, the controller answers.
interface data_memory_controller_if;

    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd_inst;
    logic [31:0] rd;
    logic        stall;

    modport master (
        output en, we, addr, wd,
        input  rd_inst, rd, stall
    );

    modport slave (
        input  en, we, addr, wd,
        output rd_inst, rd, stall
    );

endinterface

// File: rtl/data_memory_controller_sync_fifo.sv
// Synchronous FIFO with registered pointers and a combinational head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage arrays are not reset; the pointers/count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/data_memory_controller.sv
// Data-memory slave for the EX/MEM stage: block RAM, UART RX FIFO and TX holding register.
// Defining DMEM_ACCESS_TRAP_EN adds the sticky fault/fault_addr outputs for illegal accesses.
module data_memory_controller
    import data_memory_pkg::*;
#(
    parameter int RAM_WORDS = 65536,
    parameter int RX_DEPTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    data_memory_controller_if.slave bus,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [7:0]             tx_data
`ifdef DMEM_ACCESS_TRAP_EN
    ,
    output logic                   fault,
    output logic [31:0]            fault_addr
`endif
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(RX_DEPTH) + 1;

    dmem_state_t  state, state_n;
    dmem_region_t region;

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] ram_dout;
    logic        ram_en;

    logic [31:0] rd_q, rd_n;
    logic        tx_valid_n;
    logic [7:0]  tx_data_n;
    logic [7:0]  tx_hold, tx_hold_n;
    logic        rd_from_rx, rd_from_rx_n;
    logic [7:0]  rx_byte, rx_byte_n;
    logic        overrun;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;

    logic load, store, handshake, rx_bypass;

    assign load      = bus.en & ~bus.we & (state == IDLE);
    assign store     = bus.en &  bus.we & (state == IDLE);
    assign region    = decode(bus.addr, RAM_WORDS);
    assign handshake = tx_valid & tx_ready;

    // A byte arriving while a load waits on an empty FIFO goes straight to rd.
    assign rx_bypass = (state == RX_WAIT) & fifo_empty & rx_valid;
    assign fifo_push = rx_valid & ~rx_bypass;
    assign fifo_pop  = ~fifo_empty & ((load & (region == REG_RX_DATA)) | (state == RX_WAIT));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (rx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ram_en = (load | store) & (region == REG_RAM);

    always_ff @(posedge clock) begin
        if (ram_en) begin
            if (bus.we) ram[bus.addr[RAM_AW-1:0]] <= bus.wd;
            else        ram_dout <= ram[bus.addr[RAM_AW-1:0]];
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n      = state;
        rd_n         = rd_q;
        tx_valid_n   = tx_valid & ~handshake;
        tx_data_n    = tx_data;
        tx_hold_n    = tx_hold;
        rd_from_rx_n = rd_from_rx;
        rx_byte_n    = rx_byte;
        case (state)
            IDLE: begin
                if (load) begin
                    case (region)
                        REG_RAM: begin
                            rd_from_rx_n = 1'b0;
                            state_n      = RD1;
                        end
                        REG_RX_DATA: begin
                            if (!fifo_empty) begin
                                rd_from_rx_n = 1'b1;
                                rx_byte_n    = fifo_rdata;
                                state_n      = RD1;
                            end else begin
                                state_n = RX_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end else if (store && region == REG_TX_DATA) begin
                    if (!tx_valid || handshake) begin
                        tx_data_n  = bus.wd[7:0];
                        tx_valid_n = 1'b1;
                    end else begin
                        tx_hold_n = bus.wd[7:0];
                        state_n   = TX_WAIT;
                    end
                end
            end
            RD1: begin
                rd_n    = rd_from_rx ? {24'h0, rx_byte} : ram_dout;
                state_n = IDLE;
            end
            RX_WAIT: begin
                if (!fifo_empty) begin
                    rd_n    = {24'h0, fifo_rdata};
                    state_n = IDLE;
                end else if (rx_valid) begin
                    rd_n    = {24'h0, rx_data};
                    state_n = IDLE;
                end
            end
            TX_WAIT: begin
                if (handshake) begin
                    tx_data_n  = tx_hold;
                    tx_valid_n = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rd_q       <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            tx_hold    <= '0;
            rd_from_rx <= 1'b0;
            rx_byte    <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            rd_q       <= rd_n;
            tx_valid   <= tx_valid_n;
            tx_data    <= tx_data_n;
            tx_hold    <= tx_hold_n;
            rd_from_rx <= rd_from_rx_n;
            rx_byte    <= rx_byte_n;
            if (rx_valid && fifo_full && !fifo_pop) overrun <= 1'b1;
        end
    end

    assign bus.stall   = (state != IDLE);
    assign bus.rd      = rd_q;
    assign bus.rd_inst = (load && region == REG_RX_STAT) ? {23'h0, overrun, 8'(fifo_count)} : '0;

`ifdef DMEM_ACCESS_TRAP_EN
    // TX_DATA is store-only and the RX registers are load-only; anything else outside RAM traps.
    logic bad_access;
    assign bad_access = (load  && (region == REG_NONE || region == REG_TX_DATA)) ||
                        (store && (region == REG_NONE || region == REG_RX_DATA || region == REG_RX_STAT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (bad_access && !fault) begin
            fault      <= 1'b1;
            fault_addr <= bus.addr;
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_controller.sv
// Self-checking bench for data_memory_controller: directed corner cases plus random
// traffic compared against an array/queue model of RAM, RX FIFO and TX byte stream.
module tb_data_memory_controller;
    import data_memory_pkg::*;

    localparam int RAM_WORDS = 65536;
    localparam int RX_DEPTH  = 16;
    localparam int BUDGET    = 64;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       tx_ready = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
`ifdef DMEM_ACCESS_TRAP_EN
    logic        fault;
    logic [31:0] fault_addr;
`endif

    data_memory_controller_if bus ();

    data_memory_controller #(
        .RAM_WORDS (RAM_WORDS),
        .RX_DEPTH  (RX_DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data)
`ifdef DMEM_ACCESS_TRAP_EN
        ,
        .fault      (fault),
        .fault_addr (fault_addr)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [31:0] ram_m [int unsigned];
    logic [7:0]  fifo_m [$];
    bit          overrun_m = 1'b0;
    logic [7:0]  tx_sent [$];
    logic [7:0]  tx_exp [$];

    always @(posedge clock) begin
        if (reset === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) tx_sent.push_back(tx_data);
    end

    function automatic logic [31:0] stat_m();
        return {23'h0, overrun_m, 8'(fifo_m.size())};
    endfunction

    task automatic model_push(input logic [7:0] b);
        if (fifo_m.size() < RX_DEPTH) fifo_m.push_back(b);
        else overrun_m = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.stall !== 1'b0 && cycles < BUDGET) begin
            if (cycles >= 2) tx_ready = 1'b1;
            tick();
            cycles++;
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic rxv, input logic [7:0] rxb,
                          output logic [31:0] inst, output logic [31:0] rdv, output int stalls);
        bus.en = 1'b1; bus.we = w; bus.addr = a; bus.wd = d;
        rx_valid = rxv; rx_data = rxb;
        #1 inst = bus.rd_inst;
        tick();
        bus.en = 1'b0; bus.we = 1'b0; rx_valid = 1'b0;
        wait_idle(stalls);
        rdv = bus.rd;
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
        model_push(b);
    endtask

    task automatic test_reset();
        logic [31:0] inst, rdv;
        int st;
        bus.en = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wd = '0;
        reset = 1'b0;
        repeat (3) tick();
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        n_tests++; if (bus.rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h expected 0", bus.rd); end
        n_tests++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx: got valid=%b data=%h expected 0/00", tx_valid, tx_data); end
        n_tests++; if (bus.rd_inst !== 32'h0) begin n_fail++; $display("FAIL reset_rd_inst: got %h expected 0", bus.rd_inst); end
        reset = 1'b1;
        tick();
        access(1'b0, RX_STAT, 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (inst !== stat_m() || st != 0) begin n_fail++; $display("FAIL reset_status: got %h/%0d expected %h/0", inst, st, stat_m()); end
    endtask

    task automatic test_ram();
        logic [31:0] inst, rdv, a, d;
        int st;
        int unsigned pool [$];
        access(1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 8'h0, inst, rdv, st);
        ram_m[5] = 32'hDEADBEEF;
        n_tests++; if (st != 0) begin n_fail++; $display("FAIL ram_store_stall: got %0d expected 0", st); end
        access(1'b0, 32'd5, 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (st != 1) begin n_fail++; $display("FAIL ram_load_stall: got %0d expected 1", st); end
        n_tests++; if (rdv !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_load_rd: got %h expected deadbeef", rdv); end
        n_tests++; if (inst !== 32'h0) begin n_fail++; $display("FAIL ram_load_rd_inst: got %h expected 0", inst); end
        repeat (3) tick();
        n_tests++; if (bus.rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rd_hold: got %h expected deadbeef", bus.rd); end
        pool.push_back(5);
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0:       a = 32'd0;
                1:       a = 32'(RAM_WORDS - 1);
                default: a = $urandom_range(RAM_WORDS - 1);
            endcase
            d = $urandom;
            access(1'b1, a, d, 1'b0, 8'h0, inst, rdv, st);
            ram_m[a] = d;
            pool.push_back(a);
            a = pool[$urandom_range(pool.size() - 1)];
            access(1'b0, a, $urandom, 1'b0, 8'h0, inst, rdv, st);
            n_tests++;
            if (rdv !== ram_m[a] || st != 1) begin
                n_fail++; $display("FAIL ram_random @%h: got %h/%0d expected %h/1", a, rdv, st, ram_m[a]);
            end
        end
    endtask

    task automatic test_rx();
        logic [31:0] inst, rdv;
        logic [7:0] b;
        int st, wrong;
        bus.en = 1'b1; bus.we = 1'b0; bus.addr = RX_DATA;
        tick();
        bus.en = 1'b0;
        wrong = 0;
        for (int i = 0; i < 9; i++) begin
            if (bus.stall !== 1'b1) wrong++;
            tick();
        end
        rx_valid = 1'b1; rx_data = 8'h41;
        tick();
        rx_valid = 1'b0;
        n_tests++; if (wrong != 0) begin n_fail++; $display("FAIL rx_wait_stall: got %0d idle cycles expected 0", wrong); end
        n_tests++; if (bus.stall !== 1'b0 || bus.rd !== 32'h41) begin n_fail++; $display("FAIL rx_wait_rd: got stall=%b rd=%h expected 0/00000041", bus.stall, bus.rd); end
        access(1'b0, RX_STAT, 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (inst !== stat_m()) begin n_fail++; $display("FAIL rx_bypass_count: got %h expected %h", inst, stat_m()); end
        for (int i = 0; i < 3; i++) push_rx(8'($urandom));
        for (int i = 0; i < 3; i++) begin
            access(1'b0, RX_DATA, 32'h0, 1'b0, 8'h0, inst, rdv, st);
            b = fifo_m.pop_front();
            n_tests++; if (rdv !== {24'h0, b} || st != 1) begin n_fail++; $display("FAIL rx_pop: got %h/%0d expected %h/1", rdv, st, {24'h0, b}); end
        end
        push_rx(8'($urandom));
        push_rx(8'($urandom));
        b = 8'($urandom);
        access(1'b0, RX_DATA, 32'h0, 1'b1, b, inst, rdv, st);
        n_tests++; if (rdv !== {24'h0, fifo_m[0]}) begin n_fail++; $display("FAIL rx_push_pop_rd: got %h expected %h", rdv, {24'h0, fifo_m[0]}); end
        void'(fifo_m.pop_front());
        model_push(b);
        access(1'b0, RX_STAT, 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (inst !== stat_m()) begin n_fail++; $display("FAIL rx_push_pop_count: got %h expected %h", inst, stat_m()); end
        while (fifo_m.size() > 0) begin
            access(1'b0, RX_DATA, 32'h0, 1'b0, 8'h0, inst, rdv, st);
            b = fifo_m.pop_front();
            n_tests++; if (rdv !== {24'h0, b}) begin n_fail++; $display("FAIL rx_drain: got %h expected %h", rdv, {24'h0, b}); end
        end
    endtask

    task automatic test_tx();
        logic [31:0] inst, rdv;
        int st, k;
        tx_ready = 1'b0;
        tx_sent.delete();
        access(1'b1, TX_DATA, {24'($urandom), 8'h55}, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (st != 0 || tx_valid !== 1'b1 || tx_data !== 8'h55) begin n_fail++; $display("FAIL tx_first: got stall=%0d valid=%b data=%h expected 0/1/55", st, tx_valid, tx_data); end
        bus.en = 1'b1; bus.we = 1'b1; bus.addr = TX_DATA; bus.wd = {24'($urandom), 8'hAA};
        tick();
        bus.en = 1'b0; bus.we = 1'b0;
        repeat (3) tick();
        n_tests++; if (bus.stall !== 1'b1 || tx_data !== 8'h55) begin n_fail++; $display("FAIL tx_wait: got stall=%b data=%h expected 1/55", bus.stall, tx_data); end
        tx_ready = 1'b1;
        wait_idle(st);
        n_tests++; if (st != 1) begin n_fail++; $display("FAIL tx_wait_release: got %0d cycles expected 1", st); end
        k = 0;
        while (tx_valid !== 1'b0 && k < BUDGET) begin tick(); k++; end
        n_tests++;
        if (tx_sent.size() != 2 || tx_sent[0] !== 8'h55 || tx_sent[1] !== 8'hAA || k != 1) begin
            n_fail++; $display("FAIL tx_sequence: got %0d bytes after %0d cycles expected 55,aa after 1", tx_sent.size(), k);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] inst, rdv, d;
        logic [7:0] b;
        int st, k;
        int unsigned pool [4];
        tx_sent.delete();
        tx_exp.delete();
        for (int i = 0; i < 4; i++) begin
            pool[i] = $urandom_range(RAM_WORDS - 1);
            d = $urandom;
            access(1'b1, pool[i], d, 1'b0, 8'h0, inst, rdv, st);
            ram_m[pool[i]] = d;
        end
        for (int i = 0; i < 40; i++) begin
            tx_ready = 1'($urandom_range(1));
            case ($urandom_range(5))
                0: begin
                    k = $urandom_range(3); d = $urandom;
                    access(1'b1, pool[k], d, 1'b0, 8'h0, inst, rdv, st);
                    ram_m[pool[k]] = d;
                end
                1: begin
                    k = $urandom_range(3);
                    access(1'b0, pool[k], 32'h0, 1'b0, 8'h0, inst, rdv, st);
                    n_tests++; if (rdv !== ram_m[pool[k]] || st != 1) begin n_fail++; $display("FAIL b2b_ram: got %h/%0d expected %h/1", rdv, st, ram_m[pool[k]]); end
                end
                2: push_rx(8'($urandom));
                3: begin
                    if (fifo_m.size() == 0) push_rx(8'($urandom));
                    access(1'b0, RX_DATA, 32'h0, 1'b0, 8'h0, inst, rdv, st);
                    b = fifo_m.pop_front();
                    n_tests++; if (rdv !== {24'h0, b} || st != 1) begin n_fail++; $display("FAIL b2b_rx: got %h/%0d expected %h/1", rdv, st, {24'h0, b}); end
                end
                4: begin
                    access(1'b0, RX_STAT, 32'h0, 1'b0, 8'h0, inst, rdv, st);
                    n_tests++; if (inst !== stat_m() || st != 0) begin n_fail++; $display("FAIL b2b_status: got %h/%0d expected %h/0", inst, st, stat_m()); end
                end
                default: begin
                    b = 8'($urandom);
                    access(1'b1, TX_DATA, {24'($urandom), b}, 1'b0, 8'h0, inst, rdv, st);
                    tx_exp.push_back(b);
                end
            endcase
        end
        tx_ready = 1'b1;
        k = 0;
        while (tx_valid !== 1'b0 && k < BUDGET) begin tick(); k++; end
        n_tests++;
        if (tx_sent != tx_exp) begin
            n_fail++; $display("FAIL b2b_tx_stream: got %0d bytes expected %0d", tx_sent.size(), tx_exp.size());
        end
        while (fifo_m.size() > 0) begin
            access(1'b0, RX_DATA, 32'h0, 1'b0, 8'h0, inst, rdv, st);
            b = fifo_m.pop_front();
            n_tests++; if (rdv !== {24'h0, b}) begin n_fail++; $display("FAIL b2b_drain: got %h expected %h", rdv, {24'h0, b}); end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] inst, rdv;
        logic [7:0] b;
        int st;
        for (int i = 0; i < RX_DEPTH + 1; i++) push_rx(8'($urandom));
        access(1'b0, RX_STAT, 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (inst !== 32'h0000_0110) begin n_fail++; $display("FAIL overrun_status: got %h expected 00000110", inst); end
        b = 8'($urandom);
        access(1'b0, RX_DATA, 32'h0, 1'b1, b, inst, rdv, st);
        n_tests++; if (rdv !== {24'h0, fifo_m[0]}) begin n_fail++; $display("FAIL full_push_pop_rd: got %h expected %h", rdv, {24'h0, fifo_m[0]}); end
        void'(fifo_m.pop_front());
        model_push(b);
        access(1'b0, RX_STAT, 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (inst !== stat_m()) begin n_fail++; $display("FAIL full_push_pop_count: got %h expected %h", inst, stat_m()); end
        while (fifo_m.size() > 0) begin
            access(1'b0, RX_DATA, 32'h0, 1'b0, 8'h0, inst, rdv, st);
            b = fifo_m.pop_front();
            n_tests++; if (rdv !== {24'h0, b}) begin n_fail++; $display("FAIL overrun_drain: got %h expected %h", rdv, {24'h0, b}); end
        end
        access(1'b0, RX_STAT, 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (inst !== stat_m()) begin n_fail++; $display("FAIL overrun_sticky: got %h expected %h", inst, stat_m()); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] inst, rdv;
        int st;
        tx_ready = 1'b0;
        access(1'b1, TX_DATA, 32'h0000_0077, 1'b0, 8'h0, inst, rdv, st);
        access(1'b1, 32'd7, 32'hCAFE_F00D, 1'b0, 8'h0, inst, rdv, st);
        ram_m[7] = 32'hCAFE_F00D;
        access(1'b0, 32'd7, 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (rdv !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL pre_reset_rd: got %h expected cafef00d", rdv); end
        bus.en = 1'b1; bus.we = 1'b0; bus.addr = RX_DATA;
        tick();
        bus.en = 1'b0;
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL mid_rx_wait: got stall=%b expected 1", bus.stall); end
        reset = 1'b0;
        #1;
        n_tests++; if (bus.stall !== 1'b0 || bus.rd !== 32'h0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got stall=%b rd=%h tx_valid=%b expected 0/0/0", bus.stall, bus.rd, tx_valid); end
        tick();
        n_tests++; if (bus.stall !== 1'b0 || bus.rd !== 32'h0) begin n_fail++; $display("FAIL reset_held: got stall=%b rd=%h expected 0/0", bus.stall, bus.rd); end
        reset = 1'b1;
        fifo_m.delete();
        overrun_m = 1'b0;
        tick();
        access(1'b0, RX_STAT, 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (inst !== stat_m()) begin n_fail++; $display("FAIL reset_fifo_state: got %h expected %h", inst, stat_m()); end
    endtask

    task automatic test_unmapped();
        logic [31:0] inst, rdv, d0, d1;
        int st;
`ifdef DMEM_ACCESS_TRAP_EN
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b expected 0", fault); end
`endif
        access(1'b0, 32'h8000_0000, 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (inst !== 32'h0 || st != 0) begin n_fail++; $display("FAIL unmapped_load: got %h/%0d expected 0/0", inst, st); end
`ifdef DMEM_ACCESS_TRAP_EN
        n_tests++; if (fault !== 1'b1 || fault_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL fault_first: got %b/%h expected 1/80000000", fault, fault_addr); end
`endif
        access(1'b1, RX_STAT, 32'h1234_5678, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (st != 0) begin n_fail++; $display("FAIL rx_stat_store: got %0d expected 0", st); end
        d0 = $urandom; d1 = ~d0;
        access(1'b1, 32'd0, d0, 1'b0, 8'h0, inst, rdv, st);
        access(1'b1, 32'(RAM_WORDS), d1, 1'b0, 8'h0, inst, rdv, st);
        access(1'b0, 32'(RAM_WORDS), 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (inst !== 32'h0 || st != 0) begin n_fail++; $display("FAIL above_ram_load: got %h/%0d expected 0/0", inst, st); end
        access(1'b0, 32'd0, 32'h0, 1'b0, 8'h0, inst, rdv, st);
        n_tests++; if (rdv !== d0) begin n_fail++; $display("FAIL above_ram_alias: got %h expected %h", rdv, d0); end
`ifdef DMEM_ACCESS_TRAP_EN
        n_tests++; if (fault_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL fault_kept: got %h expected 80000000", fault_addr); end
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ram();
        test_rx();
        test_tx();
        test_back_to_back();
        test_overrun();
        test_reset_mid_access();
        test_unmapped();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
